// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller:
// state codes, opcodes, datapath select values and the control bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_I_EX      = 4'd10,
    S_I_WB      = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL_WB    = 4'd13,
    S_HALT      = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_BROFF = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       alusrca;
    logic       regwrite;
    logic       imm_zext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [1:0] alusrcb;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
  } ctrl_t;

  // States that wait on memory and are guarded by the timer.
  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) ||
           (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: cleared on entry to a wait state,
// advanced while the access stalls, flags the last allowed cycle.
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Count stalled cycles; saturate at the last allowed value.
  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-style controller with memory handshake,
// wait timeout and sticky illegal/timeout traps.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 16,
  parameter int EN_JAL        = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_iord,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_pcwrite,
  output logic       o_branch,
  output logic       o_branch_ne,
  output logic       o_alusrca,
  output logic       o_regwrite,
  output logic       o_imm_zext,
  output logic [1:0] o_pcsrc,
  output logic [1:0] o_aluop,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_regdst,
  output logic [1:0] o_memtoreg,
  output logic       o_illegal,
  output logic       o_timeout,
  output logic [3:0] o_state
);

  state_t state;
  state_t next;
  ctrl_t  ctrl;

  logic ready;
  logic expire;
  logic clear;
  logic count;
  logic set_illegal;
  logic set_timeout;
  logic illegal;
  logic timeout;
  logic op_logic;

  assign ready = (MEM_HANDSHAKE != 0) ? i_mem_ready : 1'b1;

  assign op_logic = (i_opcode == OP_ANDI) ||
                    (i_opcode == OP_ORI);

  // Restart the timer whenever a wait state is freshly entered.
  assign clear = is_wait(next) && (next != state);
  assign count = is_wait(state) && !ready;

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (clear),
    .count   (count),
    .expire  (expire)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state selection and trap requests.
  always_comb begin
    next        = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        if (ready) begin
          next = S_DECODE;
        end else if (expire) begin
          next        = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (i_opcode == OP_RTYPE): next = S_EXECUTE;
          (i_opcode == OP_LW),
          (i_opcode == OP_SW):    next = S_MEM_ADR;
          (i_opcode == OP_BEQ),
          (i_opcode == OP_BNE):   next = S_BRANCH;
          (i_opcode == OP_ADDI),
          (i_opcode == OP_ANDI),
          (i_opcode == OP_ORI):   next = S_I_EX;
          (i_opcode == OP_J):     next = S_JUMP;
          (i_opcode == OP_JAL) && (EN_JAL != 0):
            next = S_JAL_WB;
          default: begin
            next        = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        if (i_opcode == OP_LW) begin
          next = S_MEM_READ;
        end else begin
          next = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        if (ready) begin
          next = S_MEM_WB;
        end else if (expire) begin
          next        = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_MEM_WRITE: begin
        if (ready) begin
          next = S_FETCH;
        end else if (expire) begin
          next        = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_MEM_WB:  next = S_FETCH;
      S_EXECUTE: next = S_ALU_WB;
      S_ALU_WB:  next = S_FETCH;
      S_BRANCH:  next = S_FETCH;
      S_I_EX:    next = S_I_WB;
      S_I_WB:    next = S_FETCH;
      S_JUMP:    next = S_FETCH;
      S_JAL_WB:  next = S_FETCH;
      S_HALT:    next = S_HALT;
      default: begin
        next        = S_HALT;
        set_illegal = 1'b1;
      end
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = ALUB_FOUR;
        ctrl.irwrite = ready;
        ctrl.pcwrite = ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = ALUB_BROFF;
      end
      S_MEM_ADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUB_IMM;
      end
      S_MEM_READ: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.memtoreg = M2R_MEM;
        ctrl.regwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.regdst   = REGDST_RD;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca   = 1'b1;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.pcsrc     = PCSRC_BR;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (i_opcode == OP_BNE);
      end
      S_I_EX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.alusrcb  = ALUB_IMM;
        ctrl.aluop    = op_logic ? ALUOP_LOGIC : ALUOP_ADD;
        ctrl.imm_zext = op_logic;
      end
      S_I_WB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JMP;
        ctrl.pcwrite = 1'b1;
      end
      S_JAL_WB: begin
        ctrl.regdst   = REGDST_RA;
        ctrl.memtoreg = M2R_PC;
        ctrl.regwrite = 1'b1;
        ctrl.pcsrc    = PCSRC_JMP;
        ctrl.pcwrite  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Sticky trap flags; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      illegal <= illegal | set_illegal;
      timeout <= timeout | set_timeout;
    end
  end

  assign o_iord      = ctrl.iord;
  assign o_memread   = ctrl.memread;
  assign o_memwrite  = ctrl.memwrite;
  assign o_irwrite   = ctrl.irwrite;
  assign o_pcwrite   = ctrl.pcwrite;
  assign o_branch    = ctrl.branch;
  assign o_branch_ne = ctrl.branch_ne;
  assign o_alusrca   = ctrl.alusrca;
  assign o_regwrite  = ctrl.regwrite;
  assign o_imm_zext  = ctrl.imm_zext;
  assign o_pcsrc     = ctrl.pcsrc;
  assign o_aluop     = ctrl.aluop;
  assign o_alusrcb   = ctrl.alusrcb;
  assign o_regdst    = ctrl.regdst;
  assign o_memtoreg  = ctrl.memtoreg;
  assign o_illegal   = illegal;
  assign o_timeout   = timeout;
  assign o_state     = state;

endmodule
